regfile_commit_monitor: RTL and testbench

//  Synthesizable observer downstream of the regfile write port. Snoops every

---
 rtl/regfile_commit_monitor.sv | 142 ++++++++++++++
 tb/tb_regfile_commit_monitor.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_commit_monitor.sv
// Passive observer of the register-file write port: keeps a shadow copy of
// r1..r(NUM_REGS-1), counts writes and cycles, and streams nonzero registers on request.
module regfile_commit_monitor #(
  parameter int NUM_REGS    = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0]  ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0]  data_writeReg,
  input  logic                   dump_start,
  input  logic                   dump_ready,
  output logic                   dump_valid,
  output logic [ADDR_WIDTH-1:0]  dump_reg,
  output logic [DATA_WIDTH-1:0]  dump_data,
  output logic                   dump_done,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] write_count,
  output logic [COUNT_WIDTH-1:0] cycle_count
);

  typedef enum logic [1:0] {IDLE, SCAN, PRESENT, DONE} state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
  logic [DATA_WIDTH-1:0]  shadow_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]  shadow_d [NUM_REGS];
  logic [ADDR_WIDTH-1:0]  dump_reg_q, dump_reg_d;
  logic [DATA_WIDTH-1:0]  dump_data_q, dump_data_d;
  logic                   dump_valid_q, dump_valid_d;
  logic                   dump_done_q, dump_done_d;
  logic                   busy_q, busy_d;
  logic [COUNT_WIDTH-1:0] write_count_q, write_count_d;
  logic [COUNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
  logic                   snoop_hit;

  assign snoop_hit = ctrl_writeEnable && (ctrl_writeReg != '0) && (ctrl_writeReg <= LAST_IDX);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    dump_reg_d    = dump_reg_q;
    dump_data_d   = dump_data_q;
    write_count_d = write_count_q;
    cycle_count_d = cycle_count_q + COUNT_WIDTH'(1);

    if (snoop_hit) begin
      shadow_d[ctrl_writeReg] = data_writeReg;
      if (write_count_q != '1) begin
        write_count_d = write_count_q + COUNT_WIDTH'(1);
      end
    end

    // SCAN reads the pre-edge shadow, so a same-cycle write to idx is not seen
    unique case (state_q)
      IDLE: begin
        if (dump_start) begin
          idx_d   = ADDR_WIDTH'(1);
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (shadow_q[idx_q] != '0) begin
          dump_reg_d  = idx_q;
          dump_data_d = shadow_q[idx_q];
          state_d     = PRESENT;
        end else if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + ADDR_WIDTH'(1);
        end
      end
      PRESENT: begin
        if (dump_ready) begin
          dump_reg_d  = '0;
          dump_data_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ADDR_WIDTH'(1);
            state_d = SCAN;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    dump_valid_d = (state_d == PRESENT);
    dump_done_d  = (state_d == DONE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      dump_reg_q    <= '0;
      dump_data_q   <= '0;
      dump_valid_q  <= 1'b0;
      dump_done_q   <= 1'b0;
      busy_q        <= 1'b0;
      write_count_q <= '0;
      cycle_count_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      dump_reg_q    <= dump_reg_d;
      dump_data_q   <= dump_data_d;
      dump_valid_q  <= dump_valid_d;
      dump_done_q   <= dump_done_d;
      busy_q        <= busy_d;
      write_count_q <= write_count_d;
      cycle_count_q <= cycle_count_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  assign dump_valid  = dump_valid_q;
  assign dump_reg    = dump_reg_q;
  assign dump_data   = dump_data_q;
  assign dump_done   = dump_done_q;
  assign busy        = busy_q;
  assign write_count = write_count_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_regfile_commit_monitor.sv
// Bench for regfile_commit_monitor: directed scenarios with literal expectations
// plus a randomized run compared every cycle against a behavioural model.
module tb_regfile_commit_monitor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  wr = '0;
  logic [31:0] wd = '0;
  logic        ds = 1'b0;
  logic        dr = 1'b0;

  logic        v32, d32, b32;
  logic [4:0]  r32;
  logic [31:0] dd32, wc32, cc32;
  logic        v4, d4, b4;
  logic [4:0]  r4;
  logic [31:0] dd4;
  logic [3:0]  wc4, cc4;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 0;

  always #5 clock = ~clock;

  regfile_commit_monitor dut (
    .clock(clock), .reset(reset), .ctrl_writeEnable(we), .ctrl_writeReg(wr),
    .data_writeReg(wd), .dump_start(ds), .dump_ready(dr), .dump_valid(v32),
    .dump_reg(r32), .dump_data(dd32), .dump_done(d32), .busy(b32),
    .write_count(wc32), .cycle_count(cc32)
  );

  regfile_commit_monitor #(.COUNT_WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .ctrl_writeEnable(we), .ctrl_writeReg(wr),
    .data_writeReg(wd), .dump_start(ds), .dump_ready(dr), .dump_valid(v4),
    .dump_reg(r4), .dump_data(dd4), .dump_done(d4), .busy(b4),
    .write_count(wc4), .cycle_count(cc4)
  );

  // Behavioural model: 0 idle, 1 scanning, 2 presenting, 3 finished
  logic [31:0] m_shadow [32];
  int          m_phase = 0;
  int          m_next = 0;
  int          m_reg = 0;
  logic [31:0] m_data = '0;
  longint      m_writes = 0;
  longint      m_cycles = 0;
  int          m_done_n = 0;
  int          m_acc_reg[$];

  always @(posedge clock) begin
    if (reset) begin
      foreach (m_shadow[i]) m_shadow[i] = '0;
      m_phase = 0; m_next = 0; m_reg = 0; m_data = '0;
      m_writes = 0; m_cycles = 0;
    end else begin
      m_cycles++;
      case (m_phase)
        0: if (ds) begin m_next = 1; m_phase = 1; end
        1: begin
          if (m_shadow[m_next] != 0) begin
            m_reg = m_next; m_data = m_shadow[m_next]; m_phase = 2;
          end else if (m_next == 31) m_phase = 3;
          else m_next++;
        end
        2: if (dr) begin
          m_acc_reg.push_back(m_reg);
          if (m_next == 31) m_phase = 3;
          else begin m_next++; m_phase = 1; end
        end
        default: begin m_phase = 0; m_done_n++; end
      endcase
      if (we && wr != 0) begin
        m_shadow[wr] = wd;
        m_writes++;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [63:0] satCount(input longint n, input int w);
    longint top = (64'sd1 <<< w) - 1;
    return (n >= top) ? top : n;
  endfunction

  // Compare both instances against the model every cycle, away from the edge
  always @(negedge clock) begin
    if (cmp_en) begin
      logic [63:0] xreg, xdata;
      xreg  = (m_phase == 2) ? 64'(m_reg) : 64'd0;
      xdata = (m_phase == 2) ? 64'(m_data) : 64'd0;
      checkOutput("valid32", v32, m_phase == 2);
      checkOutput("reg32", r32, xreg);
      checkOutput("data32", dd32, xdata);
      checkOutput("done32", d32, m_phase == 3);
      checkOutput("busy32", b32, m_phase != 0);
      checkOutput("wcount32", wc32, satCount(m_writes, 32));
      checkOutput("ccount32", cc32, m_cycles & 64'hFFFF_FFFF);
      checkOutput("valid4", v4, m_phase == 2);
      checkOutput("data4", dd4, xdata);
      checkOutput("reg4", r4, xreg);
      checkOutput("done4", d4, m_phase == 3);
      checkOutput("busy4", b4, m_phase != 0);
      checkOutput("wcount4", wc4, satCount(m_writes, 4));
      checkOutput("ccount4", cc4, m_cycles & 64'hF);
    end
  end

  task automatic applyStimulus(input logic i_we, input logic [4:0] i_wr, input logic [31:0] i_wd,
                               input logic i_ds, input logic i_dr);
    we = i_we; wr = i_wr; wd = i_wd; ds = i_ds; dr = i_dr;
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  // Runs a dump with ready held high, recording every presented entry
  task automatic runDump(output int regs[$], output logic [31:0] datas[$], output int dones);
    bit finished = 0;
    regs = {}; datas = {}; dones = 0;
    applyStimulus(0, 0, 0, 1, 1);
    for (int i = 0; i < 80 && !finished; i++) begin
      if (v32) begin regs.push_back(int'(r32)); datas.push_back(dd32); end
      if (d32) begin dones++; finished = 1; end
      else applyStimulus(0, 0, 0, 0, 1);
    end
    if (!finished) checkOutput("dump_timeout", 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
  endtask

  initial begin
    int regs[$];
    logic [31:0] datas[$];
    int dones, n, done_before;
    logic [4:0]  hold_reg;
    logic [31:0] hold_data;
    bit seen;

    doReset();
    cmp_en = 1;

    // Writes to r3 counted, r0 ignored; dump shows r3 then r7
    applyStimulus(1, 5'd3, 32'h0000_1234, 0, 0);
    applyStimulus(1, 5'd0, 32'hFFFF_FFFF, 0, 0);
    checkOutput("wcount_r0_ignored", wc32, 1);
    checkOutput("model_writes", m_writes, 1);
    applyStimulus(1, 5'd7, 32'h0000_CAFE, 0, 0);
    m_acc_reg = {};
    runDump(regs, datas, dones);
    checkOutput("dump_entries", regs.size(), 2);
    if (regs.size() == 2) begin
      checkOutput("entry0_reg", regs[0], 3);
      checkOutput("entry0_data", datas[0], 32'h1234);
      checkOutput("entry1_reg", regs[1], 7);
      checkOutput("entry1_data", datas[1], 32'hCAFE);
    end
    checkOutput("dump_done_count", dones, 1);
    checkOutput("busy_after_dump", b32, 0);
    checkOutput("model_accepted", m_acc_reg.size(), 2);

    // Back-pressure holds the entry stable; a write to it is not reflected
    doReset();
    applyStimulus(1, 5'd5, 32'hAA, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (v32) seen = 1; else applyStimulus(0, 0, 0, 0, 0);
    end
    checkOutput("present_reached", seen, 1);
    hold_reg = r32; hold_data = dd32;
    checkOutput("present_data", hold_data, 32'hAA);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) applyStimulus(1, 5'd5, 32'hBB, 0, 0);
      else applyStimulus(0, 0, 0, 0, 0);
      checkOutput("stall_valid", v32, 1);
      checkOutput("stall_reg", r32, hold_reg);
      checkOutput("stall_data", dd32, 32'hAA);
    end
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("accepted_clears_valid", v32, 0);
    for (int i = 0; i < 40 && !d32; i++) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("stall_dump_done", d32, 1);
    applyStimulus(0, 0, 0, 0, 0);

    // Empty dump: done 32 edges after start is driven; restart while busy ignored
    doReset();
    done_before = m_done_n;
    applyStimulus(0, 0, 0, 1, 1);
    n = 1;
    while (!d32 && n < 60) begin
      if (n == 5) applyStimulus(0, 0, 0, 1, 1);
      else applyStimulus(0, 0, 0, 0, 1);
      checkOutput("empty_no_valid", v32, 0);
      n++;
    end
    checkOutput("empty_latency", n, 32);
    for (int i = 0; i < 40; i++) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("single_done", m_done_n - done_before, 1);
    checkOutput("idle_after_empty", b32, 0);

    // Reset while presenting aborts the dump and clears the shadow
    doReset();
    applyStimulus(1, 5'd9, 32'h55, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    for (int i = 0; i < 40 && !v32; i++) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("abort_present", v32, 1);
    done_before = m_done_n;
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    reset = 1'b0;
    checkOutput("abort_valid", v32, 0);
    checkOutput("abort_reg", r32, 0);
    checkOutput("abort_data", dd32, 0);
    checkOutput("abort_busy", b32, 0);
    checkOutput("abort_done", d32, 0);
    checkOutput("abort_wcount", wc32, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("abort_no_done", m_done_n - done_before, 0);
    runDump(regs, datas, dones);
    checkOutput("abort_shadow_empty", regs.size(), 0);

    // Narrow counters: write count saturates, cycle count wraps
    doReset();
    for (int i = 0; i < 20; i++)
      applyStimulus(1, 5'($urandom_range(1, 31)), $urandom | 32'h1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("wcount4_sat", wc4, 4'hF);
    checkOutput("wcount32_20", wc32, 20);
    doReset();
    for (int i = 0; i < 17; i++) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("ccount4_wrap", cc4, 1);
    checkOutput("ccount32_17", cc32, 17);
    checkOutput("model_cycles", m_cycles, 17);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      applyStimulus($urandom_range(0, 1), 5'($urandom_range(0, 31)),
                    ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 1));
    end
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    cmp_en = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
